// File: rtl/grant_select_sequencer.sv
// Round-robin grant sequencer feeding a 2-to-4 active-low enabled decoder.
// Select is settled one cycle before enable drops, so decoder outputs never glitch.
module grant_select_sequencer #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       en_n,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SETUP, GRANT, GAP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           state, state_nxt;
  logic [1:0]       last, last_nxt;
  logic [1:0]       sel_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             en_n_nxt, busy_nxt, timeout_nxt;
  logic             rel_cnt, rel_any;

  // First set request bit searching upward from the previous grantee, modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    logic       found;
    rr_pick = l + 2'd1;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = l + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    sel_nxt     = sel;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    rel_cnt     = (cnt == CNT_LAST);
    rel_any     = done || !req[sel] || rel_cnt;
    case (state)
      IDLE: begin
        if (req != 4'b0000) begin
          sel_nxt   = rr_pick(req, last);
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_nxt   = '0;
        state_nxt = GRANT;
      end
      GRANT: begin
        cnt_nxt = cnt + 1'b1;
        if (rel_any) begin
          state_nxt   = GAP;
          last_nxt    = sel;
          // Grantee-initiated releases outrank the hold limit.
          timeout_nxt = rel_cnt && !done && req[sel];
        end
      end
      GAP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    en_n_nxt = (state_nxt != GRANT);
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      last    <= 2'b11;
      sel     <= 2'b00;
      cnt     <= '0;
      en_n    <= 1'b1;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      sel     <= sel_nxt;
      cnt     <= cnt_nxt;
      en_n    <= en_n_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_grant_select_sequencer.sv
// Scoreboarded bench: a grant-level reference model queues expected grants,
// a negedge monitor pops them as en_n pulses appear and checks invariants.
module tb_grant_select_sequencer;

  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 8;

  localparam int M_RAND   = 0;
  localparam int M_RR     = 1;
  localparam int M_SINGLE = 2;
  localparam int M_TO     = 3;
  localparam int M_DROP   = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       en_n, busy, timeout;

  grant_select_sequencer #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .sel(sel), .en_n(en_n), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] gsel;
    int         len;
    logic       to;
  } grant_t;

  grant_t q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int model_last = 3;

  task automatic check(input string nm, input int act, input int req_v);
    n_chk++;
    if (act != req_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req_v, $time);
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] rand_req();
    if ($urandom_range(0, 3) == 0) return 4'b0000;
    return 4'($urandom_range(1, 15));
  endfunction

  function automatic int rr_winner(input logic [3:0] r, input int l);
    for (int k = 1; k <= 4; k++)
      if (r[(l + k) % 4]) return (l + k) % 4;
    return -1;
  endfunction

  // One complete grant: wait in idle, setup, hold, gap. Queues the expected pulse.
  task automatic run_grant(input int mode);
    logic [3:0] r;
    logic       d;
    int         w, len;
    bit         rel, to;
    grant_t     g;
    forever begin
      case (mode)
        M_RR:     r = 4'b1111;
        M_SINGLE: r = 4'b0100;
        M_TO:     r = 4'b0001;
        M_DROP:   r = 4'b1000;
        default:  r = rand_req();
      endcase
      drive(r, 1'($urandom_range(0, 1)));
      if (r != 4'b0000) break;
    end
    w = rr_winner(r, model_last);
    if (mode == M_RAND) drive(rand_req(), 1'($urandom_range(0, 1)));
    else drive(r, 1'b0);
    len = 0;
    forever begin
      len++;
      case (mode)
        M_RR:     begin r = 4'b1111; d = 1'b1; end
        M_SINGLE: begin r = 4'b0100; d = (len == 3); end
        M_TO:     begin r = 4'b0001; d = 1'b0; end
        M_DROP:   begin r = (len >= 3) ? 4'b0000 : 4'b1000; d = 1'b0; end
        default: begin
          r = 4'($urandom_range(0, 15));
          if ($urandom_range(0, 7) != 0) r[w] = 1'b1;
          d = ($urandom_range(0, 7) == 0);
        end
      endcase
      drive(r, d);
      rel = d || !r[w] || (len == HOLD_MAX);
      to  = !d && r[w] && (len == HOLD_MAX);
      if (rel) break;
    end
    g.gsel = 2'(w);
    g.len  = len;
    g.to   = to;
    q.push_back(g);
    model_last = w;
    if (mode == M_RAND) drive(rand_req(), 1'($urandom_range(0, 1)));
    else drive(r, 1'b1);
  endtask

  // Monitor state
  bit         in_grant;
  bit         seen_grant;
  int         run, gap;
  logic       prev_en_n, prev_busy;
  logic [1:0] prev_sel, gsel;
  grant_t     e;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_grant   = 1'b0;
      seen_grant = 1'b0;
      run        = 0;
      gap        = 0;
      prev_en_n  = 1'b1;
      prev_busy  = 1'b0;
      prev_sel   = 2'b00;
    end else begin
      check("sel_changes_only_on_setup_entry",
            int'((sel != prev_sel) && !(busy && !prev_busy)), 0);
      if (!en_n) begin
        if (prev_en_n) begin
          in_grant = 1'b1;
          run      = 0;
          gsel     = sel;
          if (seen_grant) check("gap_ge_3", int'(gap >= 3), 1);
          seen_grant = 1'b1;
        end
        run++;
        check("en_n_low_le_hold_max", int'(run <= HOLD_MAX), 1);
        check("busy_during_grant", int'(busy), 1);
        check("timeout_low_in_grant", int'(timeout), 0);
      end else if (in_grant) begin
        in_grant = 1'b0;
        gap      = 1;
        if (q.size() == 0) begin
          check("unexpected_grant", 1, 0);
        end else begin
          e = q.pop_front();
          check("grant_sel", int'(gsel), int'(e.gsel));
          check("grant_len", run, e.len);
          check("grant_timeout", int'(timeout), int'(e.to));
        end
      end else begin
        gap++;
        check("timeout_low_outside_gap_entry", int'(timeout), 0);
      end
      prev_en_n = en_n;
      prev_busy = busy;
      prev_sel  = sel;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", int'(sel), 0);
    check("rst_en_n", int'(en_n), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;

    // Partial grant to index 2, then asynchronous reset between edges.
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b0);
    check("pre_reset_en_n_low", int'(en_n), 0);
    check("pre_reset_sel", int'(sel), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en_n", int'(en_n), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_sel", int'(sel), 0);
    req = 4'b0000;
    model_last = 3;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    repeat (5) run_grant(M_RR);
    repeat (2) run_grant(M_SINGLE);
    repeat (2) run_grant(M_TO);
    run_grant(M_DROP);
    check("drop_idle_sel_held", int'(sel), 3);
    check("drop_idle_busy", int'(busy), 0);
    drive(4'b0000, 1'b1);
    check("idle_done_ignored_busy", int'(busy), 0);
    check("idle_done_ignored_en_n", int'(en_n), 1);

    while (cyc < 1200) run_grant(M_RAND);

    repeat (5) drive(4'b0000, 1'b0);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
